// File: rtl/pa_tcipif_default_slave_pkg.sv
// Shared encodings for the TCIP default slave: FSM states and response modes.
package pa_tcipif_default_slave_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } dslv_state_e;

    localparam int unsigned RESP_MODE_ALL_ERR  = 0;
    localparam int unsigned RESP_MODE_DENY_CHK = 1;

    localparam int unsigned WAIT_CYC_MAX = 15;

endpackage

// File: rtl/pa_tcipif_default_slave_icg.sv
// Latch-based integrated clock gate used by the TCIP default slave.
module gated_clk_cell (
    input  logic clk_in,
    input  logic global_en,
    input  logic module_en,
    input  logic local_en,
    input  logic external_en,
    input  logic pad_yy_icg_scan_en,
    output logic clk_out
);

    logic clk_en_bf_latch;
    logic clk_en;

    assign clk_en_bf_latch = (global_en & (module_en | local_en)) | external_en;

    // Enable is captured while the clock is low so clk_out never glitches.
    always_latch begin
        if (!clk_in) begin
            clk_en = clk_en_bf_latch | pad_yy_icg_scan_en;
        end
    end

    assign clk_out = clk_in & clk_en;

endmodule

// File: rtl/pa_tcipif_default_slave.sv
// Default slave for the TCIP instruction bus: answers every access after a fixed
// wait with an error or a constant read value, and captures the first error.
module pa_tcipif_default_slave
    import pa_tcipif_default_slave_pkg::*;
#(
    parameter int unsigned WAIT_CYC  = 0,
    parameter int unsigned RESP_MODE = 0,
    parameter logic [31:0] RDATA_VAL = 32'h0
) (
    input  logic        forever_cpuclk,
    input  logic        cpurst_b,
    input  logic        cp0_biu_icg_en,
    input  logic        pad_yy_icg_scan_en,
    input  logic        bmu_tcipif_ibus_req,
    input  logic        bmu_tcipif_ibus_req_dp,
    input  logic [31:0] bmu_tcipif_ibus_addr,
    input  logic        bmu_tcipif_ibus_write,
    input  logic        bmu_tcipif_ibus_supv_mode,
    input  logic        bmu_tcipif_ibus_acc_deny,
    input  logic [1:0]  bmu_tcipif_ibus_size,
    input  logic [31:0] bmu_tcipif_ibus_wdata,
    output logic        tcipif_bmu_ibus_grnt,
    output logic        tcipif_bmu_ibus_trans_cmplt,
    output logic        tcipif_bmu_ibus_acc_err,
    output logic [31:0] tcipif_bmu_ibus_data,
    input  logic        tcipif_err_clr,
    output logic        tcipif_err_vld,
    output logic [31:0] tcipif_err_addr,
    output logic        tcipif_err_write,
    output logic        tcipif_err_supv,
    output logic        tcipif_err_ovf
);

    if (WAIT_CYC > WAIT_CYC_MAX) begin : g_bad_wait_cyc
        $error("pa_tcipif_default_slave: WAIT_CYC must be in 0..15");
    end

    localparam logic [3:0] CNT_LOAD = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);
    localparam logic       ALL_ERR  = (RESP_MODE == RESP_MODE_ALL_ERR);

    dslv_state_e state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q;
    logic        write_q, supv_q, deny_q;
    logic        dslv_clk, local_en, accept, resp, err_cmplt;
    logic        unused_attr;

    assign unused_attr = ^{bmu_tcipif_ibus_size, bmu_tcipif_ibus_wdata};
    assign local_en    = bmu_tcipif_ibus_req_dp | (state_q != ST_IDLE) | tcipif_err_clr;

    gated_clk_cell x_tcipif_dslv_sel_clk (
        .clk_in             (forever_cpuclk),
        .global_en          (1'b1),
        .module_en          (cp0_biu_icg_en),
        .local_en           (local_en),
        .external_en        (1'b0),
        .pad_yy_icg_scan_en (pad_yy_icg_scan_en),
        .clk_out            (dslv_clk)
    );

    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        tcipif_bmu_ibus_grnt = 1'b0;
        case (state_q)
            ST_IDLE: tcipif_bmu_ibus_grnt = bmu_tcipif_ibus_req_dp;
            ST_WAIT: begin
                if (cnt_q == 4'd0) state_d = ST_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            ST_RESP: begin
                tcipif_bmu_ibus_grnt = bmu_tcipif_ibus_req_dp;
                state_d              = ST_IDLE;
                cnt_d                = '0;
            end
            default: state_d = ST_IDLE;
        endcase
        accept = bmu_tcipif_ibus_req & tcipif_bmu_ibus_grnt;
        // A grant in RESP chains the next access with no idle bubble.
        if (accept) begin
            state_d = (WAIT_CYC == 0) ? ST_RESP : ST_WAIT;
            cnt_d   = CNT_LOAD;
        end
    end

    always_ff @(posedge dslv_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            write_q <= 1'b0;
            supv_q  <= 1'b0;
            deny_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bmu_tcipif_ibus_addr;
                write_q <= bmu_tcipif_ibus_write;
                supv_q  <= bmu_tcipif_ibus_supv_mode;
                deny_q  <= bmu_tcipif_ibus_acc_deny;
            end
        end
    end

    assign resp                        = (state_q == ST_RESP);
    assign tcipif_bmu_ibus_trans_cmplt = resp;
    assign tcipif_bmu_ibus_acc_err     = resp & (ALL_ERR | deny_q);
    assign tcipif_bmu_ibus_data        = (resp & ~tcipif_bmu_ibus_acc_err & ~write_q) ? RDATA_VAL : '0;
    assign err_cmplt                   = tcipif_bmu_ibus_acc_err;

    // A new error arriving with err_clr overrides the clear.
    always_ff @(posedge dslv_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            tcipif_err_vld   <= 1'b0;
            tcipif_err_ovf   <= 1'b0;
            tcipif_err_addr  <= '0;
            tcipif_err_write <= 1'b0;
            tcipif_err_supv  <= 1'b0;
        end else if (err_cmplt) begin
            if (tcipif_err_clr || !tcipif_err_vld) begin
                tcipif_err_vld   <= 1'b1;
                tcipif_err_ovf   <= 1'b0;
                tcipif_err_addr  <= addr_q;
                tcipif_err_write <= write_q;
                tcipif_err_supv  <= supv_q;
            end else begin
                tcipif_err_ovf <= 1'b1;
            end
        end else if (tcipif_err_clr) begin
            tcipif_err_vld   <= 1'b0;
            tcipif_err_ovf   <= 1'b0;
            tcipif_err_addr  <= '0;
            tcipif_err_write <= 1'b0;
            tcipif_err_supv  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pa_tcipif_default_slave.sv
// Scoreboard bench for pa_tcipif_default_slave: three instances with different
// wait/response configurations share one clock and reset.
module tb_pa_tcipif_default_slave;

    function automatic int unsigned wcyc(input int i);
        case (i)
            0:       return 0;
            1:       return 3;
            default: return 5;
        endcase
    endfunction

    function automatic int unsigned rmode(input int i);
        return (i == 0) ? 0 : 1;
    endfunction

    function automatic logic [31:0] rdv(input int i);
        case (i)
            0:       return 32'hCAFE_0000;
            1:       return 32'hDEAD_BEEF;
            default: return 32'h1234_5678;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst_n, icg_en, scan_en;
    logic        req[3], req_dp[3], wr[3], supv[3], deny[3], clr[3];
    logic [31:0] addr[3], wdata[3];
    logic [1:0]  size[3];
    logic        grnt[3], cmplt[3], aerr[3], evld[3], ewr[3], esup[3], eovf[3];
    logic [31:0] rdata[3], eaddr[3];

    int unsigned cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    typedef struct {
        int unsigned cyc;
        logic        err;
        logic [31:0] data;
    } exp_t;
    exp_t sb[3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        pa_tcipif_default_slave #(
            .WAIT_CYC  (wcyc(g)),
            .RESP_MODE (rmode(g)),
            .RDATA_VAL (rdv(g))
        ) u_dut (
            .forever_cpuclk              (clk),
            .cpurst_b                    (rst_n),
            .cp0_biu_icg_en              (icg_en),
            .pad_yy_icg_scan_en          (scan_en),
            .bmu_tcipif_ibus_req         (req[g]),
            .bmu_tcipif_ibus_req_dp      (req_dp[g]),
            .bmu_tcipif_ibus_addr        (addr[g]),
            .bmu_tcipif_ibus_write       (wr[g]),
            .bmu_tcipif_ibus_supv_mode   (supv[g]),
            .bmu_tcipif_ibus_acc_deny    (deny[g]),
            .bmu_tcipif_ibus_size        (size[g]),
            .bmu_tcipif_ibus_wdata       (wdata[g]),
            .tcipif_bmu_ibus_grnt        (grnt[g]),
            .tcipif_bmu_ibus_trans_cmplt (cmplt[g]),
            .tcipif_bmu_ibus_acc_err     (aerr[g]),
            .tcipif_bmu_ibus_data        (rdata[g]),
            .tcipif_err_clr              (clr[g]),
            .tcipif_err_vld              (evld[g]),
            .tcipif_err_addr             (eaddr[g]),
            .tcipif_err_write            (ewr[g]),
            .tcipif_err_supv             (esup[g]),
            .tcipif_err_ovf              (eovf[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, act, exp);
        end
    endtask

    // Every completion must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (cmplt[i] === 1'b1) begin
                if (sb[i].size() == 0) begin
                    chk($sformatf("cmplt_unexpected%0d", i), 32'(cmplt[i]), 32'h0);
                end else begin
                    e = sb[i].pop_front();
                    chk($sformatf("cmplt_cyc%0d", i), cyc, e.cyc);
                    chk($sformatf("acc_err%0d", i), 32'(aerr[i]), 32'(e.err));
                    chk($sformatf("rdata%0d", i), rdata[i], e.data);
                end
            end
        end
    end

    task automatic issue(input int i, input logic [31:0] a, input logic w, input logic s, input logic d);
        logic e;
        req[i]    = 1'b1;
        req_dp[i] = 1'b1;
        addr[i]   = a;
        wr[i]     = w;
        supv[i]   = s;
        deny[i]   = d;
        size[i]   = 2'($urandom);
        wdata[i]  = $urandom;
        #1;
        for (int t = 0; t < 20 && grnt[i] !== 1'b1; t++) begin
            @(negedge clk);
            #1;
        end
        chk($sformatf("grant%0d", i), 32'(grnt[i]), 32'h1);
        if (grnt[i] === 1'b1) begin
            e = (rmode(i) == 0) | d;
            sb[i].push_back('{cyc + 1 + wcyc(i), e, (!e && !w) ? rdv(i) : 32'h0});
        end
    endtask

    task automatic idle(input int i);
        req[i]    = 1'b0;
        req_dp[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        for (int t = 0; t < 40 && sb[i].size() != 0; t++) @(negedge clk);
        chk($sformatf("drain%0d", i), 32'(sb[i].size()), 32'h0);
        @(negedge clk);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0;
        rst_n   = 1'b0;
        icg_en  = 1'b0;
        scan_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req[i] = 1'b0; req_dp[i] = 1'b1; addr[i] = '0; wr[i] = 1'b0;
            supv[i] = 1'b0; deny[i] = 1'b0; clr[i] = 1'b0; size[i] = '0; wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_grnt", 32'(grnt[i]), 32'h1);
            chk("rst_cmplt", 32'(cmplt[i]), 32'h0);
            chk("rst_acc_err", 32'(aerr[i]), 32'h0);
            chk("rst_data", rdata[i], 32'h0);
            chk("rst_err_vld", 32'(evld[i]), 32'h0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) req_dp[i] = 1'b0;
        @(negedge clk);

        // All-error slave, zero wait: supervisor read
        issue(0, 32'h4000_0000, 1'b0, 1'b1, 1'b0);
        @(negedge clk); idle(0);
        drain(0);
        chk("e36_vld", 32'(evld[0]), 32'h1);
        chk("e36_addr", eaddr[0], 32'h4000_0000);
        chk("e36_write", 32'(ewr[0]), 32'h0);
        chk("e36_supv", 32'(esup[0]), 32'h1);
        chk("e36_ovf", 32'(eovf[0]), 32'h0);

        // Three wait cycles: grant held low until the response cycle
        issue(1, 32'h0000_1234, 1'b0, 1'b0, 1'b0);
        @(negedge clk); req[1] = 1'b0;
        #1;
        for (int c = 0; c < 3; c++) begin
            chk("wait_grnt", 32'(grnt[1]), 32'h0);
            @(negedge clk); #1;
        end
        chk("resp_grnt", 32'(grnt[1]), 32'h1);
        req_dp[1] = 1'b0;
        drain(1);
        chk("ok_no_err", 32'(evld[1]), 32'h0);

        // Denied write
        issue(1, 32'h0000_0010, 1'b1, 1'b0, 1'b1);
        @(negedge clk); idle(1);
        drain(1);
        chk("e38_vld", 32'(evld[1]), 32'h1);
        chk("e38_write", 32'(ewr[1]), 32'h1);
        chk("e38_addr", eaddr[1], 32'h0000_0010);

        // Permitted write: no error, zero data, capture untouched
        issue(1, 32'h0000_0044, 1'b1, 1'b1, 1'b0);
        @(negedge clk); idle(1);
        drain(1);
        chk("okw_ovf", 32'(eovf[1]), 32'h0);
        chk("okw_addr", eaddr[1], 32'h0000_0010);

        // Back-to-back through a wait phase: second grant lands in RESP
        issue(1, 32'h0000_0080, 1'b0, 1'b0, 1'b0);
        c0 = cyc;
        @(negedge clk);
        issue(1, 32'h0000_0084, 1'b0, 1'b0, 1'b0);
        chk("b2b_wait_grant_cyc", cyc, c0 + 4);
        @(negedge clk); idle(1);
        drain(1);

        // Clear, then two back-to-back errors
        clr[0] = 1'b1;
        @(negedge clk); clr[0] = 1'b0;
        chk("clr_vld", 32'(evld[0]), 32'h0);
        chk("clr_ovf", 32'(eovf[0]), 32'h0);
        issue(0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        c0 = cyc;
        @(negedge clk);
        issue(0, 32'h0000_0200, 1'b1, 1'b0, 1'b0);
        chk("b2b_grant_cyc", cyc, c0 + 1);
        @(negedge clk); idle(0);
        drain(0);
        chk("e39_vld", 32'(evld[0]), 32'h1);
        chk("e39_addr", eaddr[0], 32'h0000_0100);
        chk("e39_write", 32'(ewr[0]), 32'h0);
        chk("e39_ovf", 32'(eovf[0]), 32'h1);

        // err_clr coincident with an error completion
        issue(0, 32'h0000_0020, 1'b0, 1'b0, 1'b0);
        @(negedge clk); idle(0); clr[0] = 1'b1;
        @(negedge clk); clr[0] = 1'b0;
        drain(0);
        chk("e40_vld", 32'(evld[0]), 32'h1);
        chk("e40_ovf", 32'(eovf[0]), 32'h0);
        chk("e40_addr", eaddr[0], 32'h0000_0020);

        // Reset in the middle of a five-cycle wait
        issue(2, 32'h0000_0300, 1'b0, 1'b1, 1'b0);
        @(negedge clk); idle(2);
        @(negedge clk);
        rst_n = 1'b0;
        sb[2].delete();
        #1;
        chk("mid_rst_cmplt", 32'(cmplt[2]), 32'h0);
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(negedge clk);
        req_dp[2] = 1'b1;
        #1;
        chk("post_rst_grnt", 32'(grnt[2]), 32'h1);
        req_dp[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("post_rst_vld", 32'(evld[i]), 32'h0);
            chk("post_rst_ovf", 32'(eovf[i]), 32'h0);
            chk("post_rst_addr", eaddr[i], 32'h0);
            chk("post_rst_write", 32'(ewr[i]), 32'h0);
            chk("post_rst_supv", 32'(esup[i]), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
